// File: rtl/axi_tx_arbiter_pkg.sv
// Shared types for the transmit arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package axi_tx_pkg;

  // IDLE: bus empty, VALID low. HOLD: a registered beat is waiting for READY.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/axi_tx_arbiter_if.sv
// Requester-side and bus-side signals of the transmit arbiter in one bundle.
// Latency: n/a (wiring only).
// Backpressure: READY from the receiver, req_ready back to each requester.
// master: the arbiter (drives VALID/xDATA/grant_id/busy/req_ready).
// slave : the environment (drives req_valid/req_data/READY).
interface axi_tx_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  VALID;
  logic [WIDTH-1:0]      xDATA;
  logic                  READY;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  modport master (
    input  req_valid, req_data, READY,
    output req_ready, VALID, xDATA, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, READY,
    input  req_ready, VALID, xDATA, grant_id, busy
  );
endinterface

// File: rtl/axi_tx_arbiter_rr_pick.sv
// Round-robin picker: first set bit of cand searching upward from ptr+1, wrapping.
// Latency: combinational.
// Backpressure: none; any=0 when cand is empty.
// Ports: cand (candidate mask), ptr (last grant) -> pick (winner index), any.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] cand,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  pick,
  output logic            any
);

  int idx;

  // Scan from the farthest offset down to the nearest so the closest
  // requester after ptr is the one left standing in pick.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (cand[idx]) begin
        pick = IDW'(idx);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_tx_arbiter.sv
// Round-robin arbiter sharing one VALID/READY transmit channel among NREQ requesters.
// Latency: req_valid in cycle t -> VALID in t+1; back-to-back beats without bubbles.
// Backpressure: READY low freezes the held beat; req_ready pulses on the completing beat.
// Ports: ACLK, ARESETn (async active-low), bus (master modport of axi_tx_arbiter_if).
module axi_tx_arbiter
  import axi_tx_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_tx_arbiter_if.master     bus
);

  arb_state_t       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0]  cand;
  logic [NREQ-1:0]  ready_vec;
  logic [IDW-1:0]   pick;
  logic             any;
  logic             hs;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .cand (cand),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    gid_d     = gid_q;
    ptr_d     = ptr_q;
    cand      = '0;
    ready_vec = '0;
    hs        = (state_q == HOLD) && bus.READY;

    // While a beat is held and not accepted, nobody may be picked. On the
    // accepting edge the finishing requester is masked so its already-sent
    // data is not loaded a second time.
    if (state_q == IDLE) begin
      cand = bus.req_valid;
    end else if (bus.READY) begin
      cand = bus.req_valid & ~(NREQ'(1) << gid_q);
    end

    if (hs) begin
      ready_vec = NREQ'(1) << gid_q;
    end

    if (any) begin
      state_d = HOLD;
      data_d  = bus.req_data[int'(pick)*WIDTH +: WIDTH];
      gid_d   = pick;
      ptr_d   = pick;
    end else if (hs) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      data_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  // VALID is the registered state itself, so it never follows READY combinationally.
  assign bus.VALID     = (state_q == HOLD);
  assign bus.busy      = (state_q == HOLD);
  assign bus.xDATA     = data_q;
  assign bus.grant_id  = gid_q;
  assign bus.req_ready = ready_vec;

endmodule

// File: tb/tb_axi_tx_arbiter.sv
// Directed bench for axi_tx_arbiter: reset, single beat, contention, backpressure,
// masking of a lone requester, and reset in the middle of a held beat.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_axi_tx_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic ACLK;
  logic ARESETn;

  axi_tx_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  axi_tx_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] d);
    bus.req_valid[i] = v;
    bus.req_data[i*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    ARESETn       = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.READY     = 1'b0;

    // Reset with random traffic and READY high: everything stays quiet.
    #1;
    bus.req_valid = 4'b1111;
    bus.req_data  = $urandom;
    bus.READY     = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(bus.VALID), 32'h0);
    chk("rst_xdata", 32'(bus.xDATA), 32'h0);
    chk("rst_gid",   32'(bus.grant_id), 32'h0);
    chk("rst_rdy",   32'(bus.req_ready), 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    bus.req_valid = '0;
    ARESETn = 1'b1;
    tick();
    chk("idle_valid", 32'(bus.VALID), 32'h0);

    // Single request from requester 2.
    set_req(2, 1'b1, 8'hA5);
    tick();
    chk("single_valid", 32'(bus.VALID), 32'h1);
    chk("single_xdata", 32'(bus.xDATA), 32'hA5);
    chk("single_gid",   32'(bus.grant_id), 32'h2);
    chk("single_rdy",   32'(bus.req_ready), 32'b0100);
    chk("single_busy",  32'(bus.busy), 32'h1);
    set_req(2, 1'b0, 8'h00);
    tick();
    chk("single_done", 32'(bus.VALID), 32'h0);
    chk("single_rdy0", 32'(bus.req_ready), 32'h0);

    // Re-reset so the pointer starts at NREQ-1 again, then full contention.
    ARESETn = 1'b0;
    #1;
    ARESETn = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(8'h10 + i));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cont_valid", 32'(bus.VALID), 32'h1);
      chk("cont_gid",   32'(bus.grant_id), 32'(i % NREQ));
      chk("cont_xdata", 32'(bus.xDATA), 32'(8'h10 + (i % NREQ)));
      chk("cont_rdy",   32'(bus.req_ready), 32'(1 << (i % NREQ)));
    end
    bus.req_valid = '0;
    tick();
    chk("cont_end", 32'(bus.VALID), 32'h0);

    // Backpressure: pointer now 0, so requester 1 wins alone, then READY held low.
    bus.READY = 1'b0;
    set_req(1, 1'b1, 8'h3C);
    tick();
    set_req(0, 1'b1, 8'h77);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.VALID), 32'h1);
      chk("bp_xdata", 32'(bus.xDATA), 32'h3C);
      chk("bp_gid",   32'(bus.grant_id), 32'h1);
      chk("bp_rdy",   32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.READY = 1'b1;
    #1;
    chk("bp_ack", 32'(bus.req_ready), 32'b0010);
    tick();
    set_req(1, 1'b0, 8'h00);
    chk("bp_next_gid",   32'(bus.grant_id), 32'h0);
    chk("bp_next_xdata", 32'(bus.xDATA), 32'h77);
    chk("bp_next_valid", 32'(bus.VALID), 32'h1);
    set_req(0, 1'b0, 8'h00);
    tick();
    chk("bp_end", 32'(bus.VALID), 32'h0);

    // Masking: a lone requester alternates beat / bubble and never repeats data.
    set_req(3, 1'b1, 8'h01);
    tick();
    chk("mask_v1",   32'(bus.VALID), 32'h1);
    chk("mask_d1",   32'(bus.xDATA), 32'h01);
    chk("mask_rdy1", 32'(bus.req_ready), 32'b1000);
    set_req(3, 1'b1, 8'h02);
    tick();
    chk("mask_v0",   32'(bus.VALID), 32'h0);
    chk("mask_d0",   32'(bus.xDATA), 32'h01);
    tick();
    chk("mask_v2",   32'(bus.VALID), 32'h1);
    chk("mask_d2",   32'(bus.xDATA), 32'h02);
    chk("mask_gid2", 32'(bus.grant_id), 32'h3);
    set_req(3, 1'b0, 8'h00);
    tick();
    chk("mask_end", 32'(bus.VALID), 32'h0);

    // Reset while a beat is held: VALID drops before any clock edge.
    bus.READY = 1'b0;
    set_req(3, 1'b1, 8'h55);
    tick();
    chk("mr_hold", 32'(bus.VALID), 32'h1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.VALID), 32'h0);
    chk("mr_rdy",   32'(bus.req_ready), 32'h0);
    chk("mr_busy",  32'(bus.busy), 32'h0);
    set_req(0, 1'b1, 8'h99);
    bus.READY = 1'b1;
    tick();
    ARESETn = 1'b1;
    tick();
    chk("mr_gid",   32'(bus.grant_id), 32'h0);
    chk("mr_xdata", 32'(bus.xDATA), 32'h99);
    chk("mr_rdy0",  32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_tx_arbiter.md
Name: axi_tx_arbiter

Overview:
- Round-robin arbiter that shares one AXI-style VALID/READY transmit channel between NREQ requesters.
- Each requester presents a valid/data pair and is acknowledged by a per-requester ready pulse.
- The arbiter registers the winner's data onto the bus and holds VALID and xDATA stable until the receiver accepts.
- Sits between several local data sources and a single channel (AW, W or AR) toward a slave.

Parameters:
- WIDTH, 8, bits per bus beat (xDATA and each requester's data).
- NREQ, 4, number of requesters; must be at least 2.
- IDW, $clog2(NREQ), width of grant_id (derived; not overridden).

Ports:
- ACLK  input  1  clock; all state updates on the rising edge.
- ARESETn  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request. Must stay high, with data stable, until that requester's req_ready is sampled high.
- req_data  input  NREQ*WIDTH  requester i's data occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot, combinational; bit i is high in the cycle requester i's beat completes on the bus.
- VALID  output  1  bus valid; registered.
- xDATA  output  WIDTH  bus data; registered.
- READY  input  1  bus ready from the receiver.
- grant_id  output  IDW  index of the requester currently owning the bus; registered.
- busy  output  1  high whenever state is HOLD.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, VALID = 0, xDATA = 0, grant_id = 0.
  - Last-grant pointer = NREQ-1, so requester 0 has highest priority first.
  - req_ready = 0.
- States: IDLE (bus idle, VALID = 0) and HOLD (VALID = 1, beat pending).
- Candidate mask:
  - In IDLE: cand = req_valid.
  - In HOLD with READY = 1: cand = req_valid with bit grant_id cleared. The finishing requester is masked so its consumed data is never re-sent.
- Pick: the first set bit of cand searching upward from (pointer+1) mod NREQ, wrapping around.
- IDLE transitions:
  - If cand is non-zero at the edge: xDATA <= req_data[pick], grant_id <= pick, pointer <= pick, VALID <= 1, go to HOLD.
  - Otherwise stay in IDLE with VALID = 0 and xDATA unchanged.
  - Latency: req_valid high in cycle t gives VALID high in cycle t+1.
- HOLD, READY = 0:
  - Stay in HOLD; VALID, xDATA and grant_id do not change.
  - No other request preempts the grant.
  - A late request from a higher-priority requester does not alter the held beat.
- HOLD, READY = 1 (handshake):
  - req_ready[grant_id] = 1 in this cycle.
  - If cand is non-zero: load the next winner exactly as in IDLE and stay in HOLD. VALID stays high (back-to-back beats, no bubble).
  - If cand is zero: VALID <= 0, go to IDLE.
- req_ready is never high in IDLE, never high while READY = 0, and never has more than one bit set.
- A lone requester issuing consecutive beats gets one beat every 2 cycles, because of the masking above. This is intended.
- A granted requester dropping req_valid mid-HOLD violates the protocol. The arbiter ignores it and completes the registered beat.
- VALID never depends combinationally on READY; VALID is asserted without waiting for READY.
- Reset asserted during HOLD: VALID drops immediately, the beat is lost, no req_ready is issued, and the pointer reinitialises.

Decomposition:
- Package axi_tx_pkg holds typedef enum logic {IDLE, HOLD} arb_state_t.
- Requester widths and IDW are computed locally from the parameters.
- Sub-module rr_pick (combinational):
  - Parameter NREQ.
  - Inputs: cand[NREQ], ptr[IDW].
  - Outputs: pick[IDW], any.
  - Instantiated once.

Test Plan:
- Reset: hold ARESETn low with random requests and READY = 1 -> VALID = 0, xDATA = 0, grant_id = 0, req_ready = 0, busy = 0.
- Single request: requester 2 sends 0xA5 in cycle t with READY = 1 -> cycle t+1 shows VALID = 1, xDATA = 0xA5, grant_id = 2, req_ready = 4'b0100; cycle t+2 shows VALID = 0.
- Full contention: all four requesters hold valid with data 0x10..0x13 and READY = 1 -> grants 0,1,2,3,0 on consecutive cycles, VALID continuously high, xDATA 0x10,0x11,0x12,0x13,0x10.
- Backpressure: grant requester 1 (0x3C) with READY low for 5 cycles while requester 0 raises valid -> VALID = 1, xDATA = 0x3C, grant_id = 1, req_ready = 0 throughout; when READY rises, req_ready = 4'b0010 and the next grant goes to 2, 3 or 0 by round-robin order.
- Masking: only requester 3 requests, with new data each beat (0x01, 0x02) and READY = 1 -> VALID pattern 1,0,1; xDATA 0x01 then 0x02; never a duplicate 0x01.
- Mid-transfer reset: pulse ARESETn low while in HOLD -> VALID falls without waiting for a clock edge; after release, requester 0 wins over requester 3 when both request.
